// File: rtl/pipe_pkg.sv
// Shared stage-metadata type and forward-select encoding for the hazard/forwarding slice.
package pipe_pkg;

  localparam int RADDR_MAX_W = 8;
  localparam int FWD_RF      = 0;

  typedef logic [RADDR_MAX_W-1:0] raddr_t;

  typedef struct packed {
    logic   valid;
    raddr_t rd;
    logic   regwrite;
    logic   load;
    raddr_t rs;
    raddr_t rt;
    logic   rs_used;
    logic   rt_used;
  } stage_meta_t;

  function automatic int ready_stage(input logic load, input int alu_rdy, input int load_rdy);
    return load ? load_rdy : alu_rdy;
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Nearest-producer priority encoder: lowest stage index >= FIRST whose result targets src.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int FIRST = 0
) (
  input  raddr_t                     src,
  input  logic                       src_used,
  input  logic [DEPTH-1:0]           stg_valid,
  input  logic [DEPTH-1:0]           stg_regwrite,
  input  raddr_t                     stg_rd [DEPTH],
  output logic                       hit,
  output logic [$clog2(DEPTH+1)-1:0] sel
);

  localparam int SEL_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = stg_valid[gi] & stg_regwrite[gi] & (stg_rd[gi] == src) &
                         (src != '0) & src_used;
    end
  endgenerate

  // Scan from the oldest stage down so the youngest producer wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k] && (k >= FIRST)) begin
        hit = 1'b1;
        sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock and operand-forward control. Forwarding is compiled in only when
// PIPE_HAZARD_FWD_EN is defined; otherwise any in-flight producer interlocks until write-back.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_RDY  = 1,
  parameter int LOAD_RDY = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [RADDR_W-1:0]         id_rs_i,
  input  logic [RADDR_W-1:0]         id_rt_i,
  input  logic [RADDR_W-1:0]         id_rd_i,
  input  logic                       id_rs_used_i,
  input  logic                       id_rt_used_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_load_i,
  input  logic                       flush_i,
  input  logic                       freeze_i,
  input  logic [XLEN-1:0]            rf_a_i,
  input  logic [XLEN-1:0]            rf_b_i,
  input  logic [DEPTH*XLEN-1:0]      stg_data_i,
  output logic                       stall_o,
  output logic                       issue_o,
  output logic [$clog2(DEPTH+1)-1:0] fwd_a_o,
  output logic [$clog2(DEPTH+1)-1:0] fwd_b_o,
  output logic [XLEN-1:0]            op_a_o,
  output logic [XLEN-1:0]            op_b_o,
  output logic                       wb_valid_o,
  output logic [RADDR_W-1:0]         wb_rd_o,
  output logic [XLEN-1:0]            wb_data_o
);

  localparam int SEL_W = $clog2(DEPTH+1);

  stage_meta_t      stg_reg  [DEPTH];
  stage_meta_t      stg_next [DEPTH];
  stage_meta_t      id_meta;
  logic [DEPTH-1:0] stg_valid, stg_regwrite, stg_load;
  raddr_t           stg_rd [DEPTH];

  raddr_t           id_src [2];
  logic [1:0]       id_used, id_hit, id_hz;
  logic [SEL_W-1:0] id_sel  [2];
  logic [SEL_W-1:0] fwd_sel [2];
  logic [XLEN-1:0]  rf_op   [2];
  logic [XLEN-1:0]  op      [2];
  logic             hazard, stall_int, issue_int;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign stg_valid[gi]    = stg_reg[gi].valid;
      assign stg_regwrite[gi] = stg_reg[gi].regwrite;
      assign stg_load[gi]     = stg_reg[gi].load;
      assign stg_rd[gi]       = stg_reg[gi].rd;
    end
  endgenerate

  assign id_src[0]  = raddr_t'(id_rs_i);
  assign id_src[1]  = raddr_t'(id_rt_i);
  assign id_used    = {id_rt_used_i, id_rs_used_i};
  assign rf_op[0]   = rf_a_i;
  assign rf_op[1]   = rf_b_i;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      pipe_fwd_match #(.DEPTH(DEPTH), .FIRST(0)) u_id_match (
        .src          (id_src[gi]),
        .src_used     (id_used[gi]),
        .stg_valid    (stg_valid),
        .stg_regwrite (stg_regwrite),
        .stg_rd       (stg_rd),
        .hit          (id_hit[gi]),
        .sel          (id_sel[gi])
      );
`ifdef PIPE_HAZARD_FWD_EN
      logic             s0_hit;
      logic [SEL_W-1:0] s0_sel;
      logic             near_load;

      pipe_fwd_match #(.DEPTH(DEPTH), .FIRST(1)) u_s0_match (
        .src          ((gi == 0) ? stg_reg[0].rs : stg_reg[0].rt),
        .src_used     ((gi == 0) ? stg_reg[0].rs_used : stg_reg[0].rt_used),
        .stg_valid    (stg_valid),
        .stg_regwrite (stg_regwrite),
        .stg_rd       (stg_rd),
        .hit          (s0_hit),
        .sel          (s0_sel)
      );

      // The consumer reaches stage 0 next cycle, by which time the producer has moved to k+1.
      assign near_load   = |(stg_load & (DEPTH'(1) << id_sel[gi]));
      assign id_hz[gi]   = id_hit[gi] &&
                           ((int'(id_sel[gi]) + 1) < ready_stage(near_load, ALU_RDY, LOAD_RDY));
      assign fwd_sel[gi] = (rst_i || !s0_hit) ? SEL_W'(FWD_RF) : s0_sel;
      assign op[gi]      = (fwd_sel[gi] == SEL_W'(FWD_RF)) ? rf_op[gi]
                                                           : stg_data_i[int'(fwd_sel[gi])*XLEN +: XLEN];
`else
      assign id_hz[gi]   = id_hit[gi] && (int'(id_sel[gi]) <= DEPTH - 2);
      assign fwd_sel[gi] = SEL_W'(FWD_RF);
      assign op[gi]      = rf_op[gi];
`endif
    end
  endgenerate

  assign hazard  = |id_hz;
  assign fwd_a_o = fwd_sel[0];
  assign fwd_b_o = fwd_sel[1];
  assign op_a_o  = op[0];
  assign op_b_o  = op[1];

  always_comb begin
    stall_int = 1'b0;
    issue_int = 1'b0;
    if (!rst_i) begin
      stall_int = freeze_i | (id_valid_i & hazard & ~flush_i);
      issue_int = id_valid_i & ~flush_i & ~stall_int;
    end
  end

  assign stall_o = stall_int;
  assign issue_o = issue_int;

  always_comb begin
    id_meta          = '0;
    id_meta.valid    = 1'b1;
    id_meta.rd       = raddr_t'(id_rd_i);
    id_meta.regwrite = id_regwrite_i;
    id_meta.load     = id_load_i;
    id_meta.rs       = raddr_t'(id_rs_i);
    id_meta.rt       = raddr_t'(id_rt_i);
    id_meta.rs_used  = id_rs_used_i;
    id_meta.rt_used  = id_rt_used_i;
  end

  always_comb begin
    stg_next = stg_reg;
    if (!freeze_i) begin
      stg_next[0] = issue_int ? id_meta : '0;
      for (int k = 1; k < DEPTH; k++) begin
        stg_next[k] = stg_reg[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (rst_i) begin
        stg_reg[k] <= '0;
      end else begin
        stg_reg[k] <= stg_next[k];
      end
    end
  end

  assign wb_valid_o = ~rst_i & stg_reg[DEPTH-1].valid & stg_reg[DEPTH-1].regwrite &
                      (stg_reg[DEPTH-1].rd != '0);
  assign wb_rd_o    = stg_reg[DEPTH-1].rd[RADDR_W-1:0];
  assign wb_data_o  = stg_data_i[(DEPTH-1)*XLEN +: XLEN];

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand/result width.
REQ-002 SHALL provide parameter RADDR_W, default 5, register address width.
REQ-003 SHALL provide parameter DEPTH, default 3, number of post-decode stages (stage 0 = EX ... DEPTH-1 = WB), legal range 2..8.
REQ-004 SHALL provide parameter ALU_RDY, default 1, first stage index at which a non-load result is valid on stg_data_i.
REQ-005 SHALL provide parameter LOAD_RDY, default 2, first stage index at which a load result is valid; LOAD_RDY >= ALU_RDY, LOAD_RDY <= DEPTH-1.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset (synchronous, active-high); one clock only.
REQ-007 SHALL have ports: id_valid_i in 1; id_rs_i, id_rt_i, id_rd_i in RADDR_W; id_rs_used_i, id_rt_used_i, id_regwrite_i, id_load_i in 1 (decode-stage instruction).
REQ-008 SHALL have ports: flush_i in 1 kill ID instruction; freeze_i in 1 hold entire pipeline.
REQ-009 SHALL have ports: rf_a_i, rf_b_i in XLEN (register-file operands of stage-0 instruction); stg_data_i in DEPTH*XLEN (stage k result at bits k*XLEN+:XLEN).
REQ-010 SHALL have ports: stall_o out 1; issue_o out 1; fwd_a_o, fwd_b_o out $clog2(DEPTH+1) (0 = register file, k = stage k); op_a_o, op_b_o out XLEN.
REQ-011 SHALL have ports: wb_valid_o out 1; wb_rd_o out RADDR_W; wb_data_o out XLEN (retiring write from stage DEPTH-1).

Function
REQ-012 SHALL hold per-stage metadata registers: valid, rd, regwrite, load, rs, rt, rs_used, rt_used.
REQ-013 SHALL, when freeze_i=0, shift metadata stage k -> k+1 each cycle; stage 0 loads ID fields if issue_o=1, else a bubble (valid=0).
REQ-014 SHALL, when freeze_i=1, hold all stage registers unchanged, force issue_o=0 and stall_o=1.
REQ-015 SHALL define producer match at stage k: valid & regwrite & rd==src & src!=0 & src_used.
REQ-016 SHALL assert hazard when an ID source's nearest (lowest k) matching stage k satisfies k+1 < rdy, rdy = LOAD_RDY if load else ALU_RDY.
REQ-017 SHALL drive stall_o = freeze_i | (id_valid_i & hazard & ~flush_i), combinationally.
REQ-018 SHALL drive issue_o = id_valid_i & ~flush_i & ~stall_o; flush_i with hazard in same cycle: flush wins, stall_o=0 (unless freeze_i).
REQ-019 SHALL select fwd_a_o/fwd_b_o for the stage-0 instruction as the nearest matching stage k in 1..DEPTH-1, else 0; op_x_o = fwd 0 ? rf_x_i : stg_data_i[k].
REQ-020 SHALL drive wb_valid_o = stage DEPTH-1 valid & regwrite & rd!=0, wb_rd_o = its rd, wb_data_o = stg_data_i[DEPTH-1].
REQ-021 SHALL require write-before-read register file; stage DEPTH-1 producers never cause stall.
REQ-022 SHALL have zero-cycle (combinational) latency from stage registers to stall/forward outputs; one-cycle latency ID -> stage 0.

Reset
REQ-023 SHALL, on rst_i=1 at clk_i rising edge, clear all stage valid bits and metadata to 0.
REQ-024 SHALL, while rst_i=1, force stall_o=0, issue_o=0, fwd_a_o=fwd_b_o=0, wb_valid_o=0; rst_i overrides freeze_i and flush_i.
REQ-025 SHALL, on reset mid-operation, discard all in-flight instructions; no wb_valid_o pulse in the cycle after reset.

Configuration
REQ-026 SHALL compile forwarding in when PIPE_HAZARD_FWD_EN is defined: behaviour per REQ-016/REQ-019.
REQ-027 SHALL, without PIPE_HAZARD_FWD_EN, tie fwd_a_o/fwd_b_o to 0, op_x_o = rf_x_i, and assert hazard on any match in stages 0..DEPTH-2 regardless of rdy.

Structure
REQ-028 SHALL place forward-select encoding constants (FWD_RF=0) and stage-metadata struct typedef in shared package pipe_pkg.
REQ-029 SHALL instantiate sub-module pipe_fwd_match (one per operand, per use: ID hazard, stage-0 forward) implementing nearest-match priority encode.
REQ-030 SHALL be sized for 120-400 lines RTL excluding package.

Verification
REQ-031 SHALL cover: lw $2 then add $3,$2,$4 (defaults) -> stall_o=1 one cycle, bubble at stage 0, then fwd_a_o=2, op_a_o=stg_data_i[2].
REQ-032 SHALL cover: add $5,$1,$1 then sub $6,$5,$5 -> no stall, fwd_a_o=fwd_b_o=1 for sub in stage 0.
REQ-033 SHALL cover: $5 written by stages 1 and 2 simultaneously -> fwd selects 1 (nearest).
REQ-034 SHALL cover: add $0,... then use $0 -> no stall, fwd=0, wb_valid_o=0.
REQ-035 SHALL cover: load-use hazard with flush_i=1 same cycle -> stall_o=0, issue_o=0; freeze_i=1 three cycles -> stage contents unchanged.
REQ-036 SHALL cover: DEPTH=5, LOAD_RDY=4, without PIPE_HAZARD_FWD_EN, lw then dependent use -> stall_o=1 four cycles, op_a_o=rf_a_i.
